// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, FSM encoding and flag bit positions.
package cpu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB = 4'h1;
    localparam logic [OP_W-1:0] OP_AND = 4'h2;
    localparam logic [OP_W-1:0] OP_OR  = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR = 4'h4;
    localparam logic [OP_W-1:0] OP_NOT = 4'h5;
    localparam logic [OP_W-1:0] OP_SHL = 4'h6;
    localparam logic [OP_W-1:0] OP_SHR = 4'h7;
    localparam logic [OP_W-1:0] OP_LDA = 4'h8;
    localparam logic [OP_W-1:0] OP_LDB = 4'h9;
    localparam logic [OP_W-1:0] OP_STC = 4'hA;
    localparam logic [OP_W-1:0] OP_LDI = 4'hB;
    localparam logic [OP_W-1:0] OP_JMP = 4'hC;
    localparam logic [OP_W-1:0] OP_JZ  = 4'hD;
    localparam logic [OP_W-1:0] OP_CMP = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam int unsigned FLAG_Z    = 0;
    localparam int unsigned FLAG_C    = 1;
    localparam int unsigned FLAG_EQ   = 2;
    localparam int unsigned FLAG_GT   = 3;
    localparam int unsigned FLAG_LT   = 4;
    localparam int unsigned NUM_FLAGS = 5;

    function automatic logic is_busy(input state_e s);
        return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for opcodes 0-7; carry holds carry-out, borrow or the shifted-out bit.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] y,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        y     = '0;
        carry = 1'b0;
        case ({1'b0, op})
            OP_ADD: {carry, y} = sum;
            OP_SUB: begin
                y     = a - b;
                carry = (a < b);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: begin
                y     = {a[DATA_W-2:0], 1'b0};
                carry = a[DATA_W-1];
            end
            OP_SHR: begin
                y     = {1'b0, a[DATA_W-1:1]};
                carry = a[0];
            end
            default: ;
        endcase
        zero = (y == '0);
    end

endmodule

// File: rtl/cpu_core_p.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/EXEC(/MEM) sequencer, PC/IR/A/B/C, flags,
// instruction and data memories, and a program-load port usable while idle or halted.
module cpu_core_p
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned IM_AW  = 8,
    parameter int unsigned DM_AW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              prog_we,
    input  logic [IM_AW-1:0]  prog_addr,
    input  logic [ADDR_W+3:0] prog_data,
    output logic              busy,
    output logic              halted,
    output logic [IM_AW-1:0]  pc,
    output logic [DATA_W-1:0] acc,
    output logic              za,
    output logic              zb,
    output logic              eq,
    output logic              gt,
    output logic              lt,
    output logic              z,
    output logic              c
);

    localparam int unsigned IW       = 4 + ADDR_W;
    localparam int unsigned IM_DEPTH = 1 << IM_AW;
    localparam int unsigned DM_DEPTH = 1 << DM_AW;

    state_e                 state_q, state_d;
    logic [IM_AW-1:0]       pc_q, pc_d;
    logic [IW-1:0]          ir_q, ir_d;
    logic [DATA_W-1:0]      a_q, a_d, b_q, b_d, c_q, c_d;
    logic [DATA_W-1:0]      dm_rdata_q, dm_rdata_d;
    logic [NUM_FLAGS-1:0]   flags_q, flags_d;
    logic                   busy_q, busy_d, halted_q, halted_d;
    logic                   za_q, za_d, zb_q, zb_d;

    logic [IW-1:0]          im_mem [IM_DEPTH];
    logic [DATA_W-1:0]      dm_mem [DM_DEPTH];

    logic [OP_W-1:0]        op_c;
    logic [ADDR_W-1:0]      fld_c;
    logic [IM_AW-1:0]       pc_inc_c;
    logic [DATA_W-1:0]      ldi_val_c;
    logic                   idle_or_halt_c;
    logic                   im_we_c, dm_we_c;
    logic [DATA_W-1:0]      alu_y;
    logic                   alu_carry, alu_zero;

    assign op_c           = ir_q[ADDR_W+3:ADDR_W];
    assign fld_c          = ir_q[ADDR_W-1:0];
    assign pc_inc_c       = pc_q + IM_AW'(1);
    assign ldi_val_c      = DATA_W'(fld_c);
    assign idle_or_halt_c = (state_q == ST_IDLE) || (state_q == ST_HALT);
    // Program loads bypass en; a store in flight when reset hits is dropped.
    assign im_we_c        = prog_we && idle_or_halt_c && !rst;
    assign dm_we_c        = en && !rst && (state_q == ST_EXEC) && (op_c == OP_STC);

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a     (a_q),
        .b     (b_q),
        .op    (op_c[2:0]),
        .y     (alu_y),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                ST_IDLE, ST_HALT: if (start) state_d = ST_FETCH;
                ST_FETCH:         state_d = ST_DECODE;
                ST_DECODE:        state_d = ST_EXEC;
                ST_EXEC: begin
                    if ((op_c == OP_LDA) || (op_c == OP_LDB)) begin
                        state_d = ST_MEM;
                    end else if (op_c == OP_HLT) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_MEM:           state_d = ST_FETCH;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next-values; everything holds unless the current state acts on it.
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        dm_rdata_d = dm_rdata_q;
        flags_d    = flags_q;
        if (en) begin
            case (state_q)
                ST_IDLE, ST_HALT: if (start) pc_d = '0;
                ST_FETCH:         ir_d = im_mem[pc_q];
                ST_EXEC: begin
                    case (op_c)
                        OP_ADD, OP_SUB, OP_AND, OP_OR,
                        OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
                            c_d             = alu_y;
                            flags_d[FLAG_Z] = alu_zero;
                            flags_d[FLAG_C] = alu_carry;
                            pc_d            = pc_inc_c;
                        end
                        OP_LDA, OP_LDB: dm_rdata_d = dm_mem[fld_c[DM_AW-1:0]];
                        OP_STC:         pc_d = pc_inc_c;
                        OP_LDI: begin
                            c_d             = ldi_val_c;
                            flags_d[FLAG_Z] = (ldi_val_c == '0);
                            pc_d            = pc_inc_c;
                        end
                        OP_JMP:         pc_d = fld_c[IM_AW-1:0];
                        OP_JZ:          pc_d = flags_q[FLAG_Z] ? fld_c[IM_AW-1:0] : pc_inc_c;
                        OP_CMP: begin
                            flags_d[FLAG_EQ] = (a_q == b_q);
                            flags_d[FLAG_GT] = (a_q > b_q);
                            flags_d[FLAG_LT] = (a_q < b_q);
                            pc_d             = pc_inc_c;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    if (op_c == OP_LDA) begin
                        a_d = dm_rdata_q;
                    end else begin
                        b_d = dm_rdata_q;
                    end
                    pc_d = pc_inc_c;
                end
                default: ;
            endcase
        end
        busy_d   = is_busy(state_d);
        halted_d = (state_d == ST_HALT);
        za_d     = (a_d == '0);
        zb_d     = (b_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            dm_rdata_q <= '0;
            flags_q    <= '0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            za_q       <= 1'b1;
            zb_q       <= 1'b1;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            dm_rdata_q <= dm_rdata_d;
            flags_q    <= flags_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
            za_q       <= za_d;
            zb_q       <= zb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (im_we_c) im_mem[prog_addr] <= prog_data;
        if (dm_we_c) dm_mem[fld_c[DM_AW-1:0]] <= c_q;
    end

    assign busy   = busy_q;
    assign halted = halted_q;
    assign pc     = pc_q;
    assign acc    = c_q;
    assign za     = za_q;
    assign zb     = zb_q;
    assign z      = flags_q[FLAG_Z];
    assign c      = flags_q[FLAG_C];
    assign eq     = flags_q[FLAG_EQ];
    assign gt     = flags_q[FLAG_GT];
    assign lt     = flags_q[FLAG_LT];

endmodule
